// File: rtl/rectify_clip_if.sv
// rtl/rectify_clip_if.sv - step-control and memory-port bundle for rectify_clip
//
// Signals (directions given for the master modport, which the rectifier uses):
//   run          in   step-start level from the step sequencer
//   done         out  one-cycle step-complete pulse
//   src_rd_en    out  source gradient memory read strobe
//   src_rd_addr  out  source read address
//   src_rd_data  in   signed gradient, valid one cycle after src_rd_en
//   dst_wr_en    out  destination pixel memory write strobe
//   dst_wr_addr  out  destination write address
//   dst_wr_data  out  rectified, clipped pixel
//   sat_cnt      out  clipped-pixel count (only with RECTIFY_CLIP_SAT_CNT_EN)
// The slave modport is the mirror image, for the sequencer/memory side.
// Optional feature macro: RECTIFY_CLIP_SAT_CNT_EN
interface rectify_clip_if #(
    parameter int ADDR_W = 12,
    parameter int GRD_W  = 12,
    parameter int PIX_W  = 8
);
    logic                     run;
    logic                     done;
    logic                     src_rd_en;
    logic        [ADDR_W-1:0] src_rd_addr;
    logic signed [GRD_W-1:0]  src_rd_data;
    logic                     dst_wr_en;
    logic        [ADDR_W-1:0] dst_wr_addr;
    logic        [PIX_W-1:0]  dst_wr_data;
`ifdef RECTIFY_CLIP_SAT_CNT_EN
    logic        [ADDR_W:0]   sat_cnt;

    modport master (
        input  run, src_rd_data,
        output done, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data, sat_cnt
    );
    modport slave (
        output run, src_rd_data,
        input  done, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data, sat_cnt
    );
`else
    modport master (
        input  run, src_rd_data,
        output done, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data
    );
    modport slave (
        output run, src_rd_data,
        input  done, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data
    );
`endif
endinterface

// File: rtl/rectify_clip.sv
// rtl/rectify_clip.sv - streams a gradient image through |x| and clips it to pixel range
//
// Reads IMG_W*IMG_H signed gradients from the source memory, writes
// min(|g|, 2^PIX_W-1) to the same address of the destination memory, and
// reports completion to the step sequencer with a one-cycle done pulse.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - rectify_clip_if.master (run/done handshake, source read port,
//          destination write port, optional sat_cnt)
// Optional feature macro: RECTIFY_CLIP_SAT_CNT_EN (adds the clipped-pixel counter)
module rectify_clip #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int GRD_W  = 12,
    parameter int PIX_W  = 8,
    // a 1x1 image would give a zero-width address, so floor it at one bit
    parameter int ADDR_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
    input  logic           clk,
    input  logic           rst,
    rectify_clip_if.master bus
);
    localparam int N  = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
    // comparison width wide enough for both |g| (GRD_W+1 bits) and the pixel max
    localparam int CW = (GRD_W >= PIX_W) ? GRD_W + 1 : PIX_W + 1;
    localparam logic [CW-1:0] PIX_MAX = {{(CW - PIX_W){1'b0}}, {PIX_W{1'b1}}};

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_DRAIN    = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_WAIT_LOW = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_drain;
    logic              r_rd_vld;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;

    logic              w_rd_en;
    logic              w_start;
    logic              w_abort;
    logic [GRD_W:0]    w_ext;
    logic [GRD_W:0]    w_mag;
    logic [CW-1:0]     w_mag_c;
    logic              w_sat;
    logic [PIX_W-1:0]  w_pix;

    assign w_rd_en = (r_state == S_READ);
    assign w_start = (r_state == S_IDLE) && bus.run;
    // dropping run mid-step kills the step and everything still in the pipe
    assign w_abort = ((r_state == S_READ) || (r_state == S_DRAIN)) && !bus.run;

    // one extra bit so |-2^(GRD_W-1)| is representable before clipping
    assign w_ext   = {bus.src_rd_data[GRD_W-1], bus.src_rd_data};
    assign w_mag   = w_ext[GRD_W] ? (~w_ext + {{GRD_W{1'b0}}, 1'b1}) : w_ext;
    assign w_mag_c = CW'(w_mag);
    assign w_sat   = (w_mag_c > PIX_MAX);
    assign w_pix   = w_sat ? {PIX_W{1'b1}} : w_mag_c[PIX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_drain   <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_state <= S_READ;
                        r_cnt   <= '0;
                    end
                end
                S_READ: begin
                    if (!bus.run) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == LAST) begin
                        r_state <= S_DRAIN;
                        r_drain <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // two cycles: lets the last read land and then be written
                    if (!bus.run) begin
                        r_state <= S_IDLE;
                    end else if (r_drain) begin
                        r_state <= S_DONE;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_DONE:     r_state <= S_WAIT_LOW;
                // a held run must not retrigger the step
                S_WAIT_LOW: if (!bus.run) r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase

            // stage 1 tracks the read whose data arrives this cycle,
            // stage 2 holds the registered pixel being written
            r_rd_vld  <= w_rd_en && !w_abort;
            r_rd_addr <= r_cnt;
            r_wr_en   <= r_rd_vld && !w_abort;
            if (r_rd_vld) begin
                r_wr_addr <= r_rd_addr;
                r_wr_data <= w_pix;
            end
        end
    end

    assign bus.done        = (r_state == S_DONE);
    assign bus.src_rd_en   = w_rd_en;
    assign bus.src_rd_addr = r_cnt;
    assign bus.dst_wr_en   = r_wr_en;
    assign bus.dst_wr_addr = r_wr_addr;
    assign bus.dst_wr_data = r_wr_data;

`ifdef RECTIFY_CLIP_SAT_CNT_EN
    logic            r_wr_sat;
    logic [ADDR_W:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_sat  <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            if (r_rd_vld) r_wr_sat <= w_sat;
            // count a clipped pixel only when its write actually goes out
            if (w_start) begin
                r_sat_cnt <= '0;
            end else if (r_wr_en && r_wr_sat) begin
                r_sat_cnt <= r_sat_cnt + (ADDR_W + 1)'(1);
            end
        end
    end

    assign bus.sat_cnt = r_sat_cnt;
`endif
endmodule

// File: doc/rectify_clip.md
RECTIFY_CLIP -- requirements
Module: rectify_clip

Interface
- REQ-001: Parameter IMG_W, default 64, image width in pixels.
- REQ-002: Parameter IMG_H, default 64, image height in pixels.
- REQ-003: Parameter GRD_W, default 12, width of the signed two's-complement gradient sample.
- REQ-004: Parameter PIX_W, default 8, width of the unsigned output pixel.
- REQ-005: Parameter ADDR_W, default $clog2(IMG_W*IMG_H), width of the pixel address.
- REQ-006: Ports SHALL be, one clock and a synchronous active-high reset:
  - clk  in  1  clock; all logic on posedge.
  - rst  in  1  reset; synchronous, active-high.
  - run  in  1  step-start level from the step sequencer; held high until done is seen.
  - done  out  1  one-cycle step-complete pulse to the step sequencer.
  - src_rd_en  out  1  source gradient memory read strobe.
  - src_rd_addr  out  ADDR_W  source read address.
  - src_rd_data  in  GRD_W  signed gradient, valid exactly one cycle after src_rd_en.
  - dst_wr_en  out  1  destination pixel memory write strobe.
  - dst_wr_addr  out  ADDR_W  destination write address.
  - dst_wr_data  out  PIX_W  rectified, clipped pixel.
  - sat_cnt  out  ADDR_W+1  clipped-pixel count; present only with RECTIFY_CLIP_SAT_CNT_EN.

Function
- REQ-007: The block SHALL have five states: IDLE, READ, DRAIN, DONE, WAIT_LOW.
- REQ-008: IDLE->READ SHALL occur on the edge where run=1; the read counter SHALL clear to 0.
- REQ-009: In READ, src_rd_en SHALL be 1 and src_rd_addr SHALL equal the counter; the counter SHALL increment each cycle.
- REQ-010: READ->DRAIN SHALL occur after address N-1 is issued (N=IMG_W*IMG_H); DRAIN SHALL last exactly 2 cycles, then go to DONE.
- REQ-011: Each pixel SHALL be computed as min(|src_rd_data|, 2^PIX_W-1); |-2^(GRD_W-1)| SHALL be handled without overflow (result clipped).
- REQ-012: Each pixel SHALL be registered; dst_wr_en/dst_wr_addr/dst_wr_data SHALL appear 2 cycles after the corresponding src_rd_en cycle with dst_wr_addr equal to the read address.
- REQ-013: With run sampled at edge 0: src_rd_en high cycles 1..N; dst_wr_en high cycles 3..N+2; done high in cycle N+3 only.
- REQ-014: DONE SHALL last one cycle, then go to WAIT_LOW; WAIT_LOW->IDLE SHALL occur when run=0, so a held run never restarts the step.
- REQ-015: run=0 in READ or DRAIN SHALL abort: next state IDLE, src_rd_en=0 from the next cycle, in-flight writes suppressed, done never asserted.
- REQ-016: Outside READ, src_rd_en SHALL be 0; dst_wr_en SHALL never be 1 for an address not read in the current step.

Reset
- REQ-017: rst=1 SHALL force state IDLE, counter 0, write pipeline invalid, and sat_cnt 0 on the next edge, overriding all other inputs, including mid-step.
- REQ-018: Reset values SHALL be: done=0, src_rd_en=0, src_rd_addr=0, dst_wr_en=0, dst_wr_addr=0, dst_wr_data=0, sat_cnt=0.

Configuration
- REQ-019: Macro RECTIFY_CLIP_SAT_CNT_EN defined: sat_cnt SHALL clear on IDLE->READ and increment on each dst_wr_en whose |value| exceeded 2^PIX_W-1, holding its value after done until the next start.
- REQ-020: Macro undefined: the sat_cnt port and logic SHALL be absent; all other behaviour is identical.

Verification
- REQ-021: IMG 4x4, src=[0,1,-1,255,256,-256,2047,-2048,...], run held high -> dst=[0,1,1,255,255,255,255,255,...]; done in cycle 19 only; sat_cnt=4.
- REQ-022: run held high 10 cycles after done -> no second src_rd_en; run low then high -> step repeats with identical writes.
- REQ-023: run dropped in cycle 5 -> src_rd_en low from cycle 6; no dst_wr_en after cycle 6; no done; next run gives a full clean step.
- REQ-024: rst pulsed in cycle N/2 with run high -> all outputs at reset values the next cycle; restart after rst falls with run high.
- REQ-025: IMG 1x1, src=-7 -> single write of 7 to address 0 in cycle 3; done in cycle 4.
